spi_cmd_sched: RTL and testbench
================================

# spi_cmd_sched

Command scheduler that shares the single `spi_master` between two requesters: a host command FIFO (PCIe register path) and an internal periodic poll engine that reads an ISFET chip status word. It arbitrates between them, runs the `spi_rdy`/`spi_req`/`spi_ack` handshake, and routes each 16-bit read-back word to its requester. It sits between the PCIe register bank and `spi_master`, in the `spi_clk` domain.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: host command FIFO depth; power of 2, at least 2.
- `POLL_PERIOD`, default 1000: `spi_clk` cycles between poll triggers; at least 2.
- `POLL_CMD`, default 16'h8000: word sent on every poll transaction.

Ports:
- `spi_clk`, in, 1: clock.
- `spi_nrst`, in, 1: reset, asynchronous, active-low.
- `host_cmd`, in, 16: host command word.
- `host_cmd_valid`, in, 1: push strobe for `host_cmd`, one word per cycle.
- `host_cmd_full`, out, 1: FIFO full.
- `host_drop`, out, 1: sticky flag; a push was attempted while the FIFO was full.
- `host_rsp`, out, 16: read-back word for the last host command.
- `host_rsp_valid`, out, 1: one-cycle pulse when `host_rsp` is updated.
- `poll_en`, in, 1: enables the poll engine.
- `poll_data`, out, 16: last poll read-back word.
- `poll_valid`, out, 1: one-cycle pulse when `poll_data` is updated.
- `poll_miss`, out, 1: sticky flag; a poll trigger fired while the previous poll was still pending.
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `spi_rdy`, in, 1: from `spi_master`.
- `spi_ack`, in, 1: from `spi_master`.
- `spi_in`, in, 16: from `spi_master` (`SPI_IN`).
- `spi_req`, out, 1: to `spi_master`.
- `spi_out`, out, 16: to `spi_master` (`SPI_OUT`).

## Operation
- Reset values: all outputs are 0; FIFO empty; poll timer 0; `poll_pend` 0; `last_grant` = POLL, so the host wins the first tie; state IDLE.
- FIFO
  - A push when not full writes the word. A push when full drops the word and sets `host_drop`.
  - `host_cmd_full` is registered and reflects the count after the current edge.
  - A push and a pop in the same cycle are both honoured; the count is unchanged.
- Poll timer
  - While `poll_en` is high, the timer counts 0..POLL_PERIOD-1 and wraps.
  - At terminal count it sets `poll_pend`. If `poll_pend` is already set, it sets `poll_miss` instead and does not queue a second trigger.
  - `poll_en` low clears the timer and `poll_pend`. A poll already granted still completes.
- FSM states:
  - IDLE: when `spi_rdy` is high and at least one requester is pending, grant at this edge:
    - Latch `spi_out` with the FIFO head (and pop it) or with POLL_CMD (and clear `poll_pend`).
    - Record `sel` and `last_grant`; set `spi_req` to 1; go to REQ.
    - Tie-break: grant the requester that is not `last_grant`.
    - Otherwise remain in IDLE.
  - REQ: hold `spi_req` high and `spi_out` stable. When `spi_ack` is sampled high:
    - Capture `spi_in` into `host_rsp` or `poll_data` according to `sel`, and pulse the matching valid flag.
    - Clear `spi_req`; go to REL.
  - REL: wait for `spi_ack` low and `spi_rdy` high, then go to IDLE.
- `spi_out` changes only at a grant edge and never while `spi_req` is high.
- Exactly one valid pulse is produced per granted transaction.

## Timing
- Grant: `spi_req` rises 1 cycle after the first cycle in which `spi_rdy` and a pending request are both sampled high.
- Capture: `host_rsp`/`poll_data` and the valid pulse appear at the edge where `spi_ack` is sampled high. `spi_req` falls at the same edge.
- Back-to-back: the next grant can occur no earlier than the first IDLE cycle with `spi_rdy` high. Between transactions there are at least 2 cycles of `spi_req` low.
- Push to `spi_req` with the FIFO previously empty and `spi_master` idle: 2 cycles.
- Reset asserted mid-transaction: everything returns to reset values asynchronously, including `spi_req`=0. The partial response is discarded and no valid pulse is produced. `spi_master` shares `spi_nrst`.
- Poll trigger on the same edge as a host push, both requesters then pending: arbitration follows `last_grant`.

## Test plan
- Host path: after reset, push 16'hA5A5 with a `spi_master` model returning 16'h1234 → `spi_out`=16'hA5A5 while `spi_req` is high; one `host_rsp_valid` pulse with `host_rsp`=16'h1234; `poll_valid` never asserts.
- Poll path: POLL_PERIOD=20, `poll_en`=1, model returns 16'h00C3 → every 20 cycles `spi_out`=16'h8000 and one `poll_valid` pulse with `poll_data`=16'h00C3.
- Overflow: FIFO_DEPTH=4 with `spi_rdy` held low, push 5 words → `host_cmd_full`=1 after the 4th push; `host_drop`=1; after release, exactly 4 transactions complete in push order.
- Arbitration: host word pending and a poll trigger on the same cycle, then hold both pending → first grant is host, then poll and host alternate; no requester is granted twice in a row while the other is pending.
- Poll miss: POLL_PERIOD=4 with the model taking 10 cycles to ack → `poll_miss`=1; only one poll is queued per transaction.
- Reset mid-REQ: deassert `spi_nrst` while `spi_req`=1 → `spi_req`=0 immediately; no valid pulse; FIFO empty; the next push completes normally.

Source files
------------

// File: rtl/spi_cmd_sched.sv
// ---------------------------------------------------------------------------
// spi_cmd_sched
//   Shares one spi_master between a host command FIFO and a periodic poll
//   engine. Arbitrates round-robin on ties, runs the spi_rdy/spi_req/spi_ack
//   handshake and routes each 16-bit read-back word to its requester.
//
// Ports
//   spi_clk, spi_nrst         : clock, asynchronous active-low reset
//   host_cmd/_valid           : host command push (one word per cycle)
//   host_cmd_full, host_drop  : FIFO full, sticky push-while-full flag
//   host_rsp/_valid           : host read-back word and one-cycle pulse
//   poll_en                   : poll engine enable
//   poll_data/_valid          : poll read-back word and one-cycle pulse
//   poll_miss                 : sticky trigger-while-pending flag
//   busy                      : scheduler FSM not idle
//   spi_rdy, spi_ack, spi_in  : from spi_master
//   spi_req, spi_out          : to spi_master
// ---------------------------------------------------------------------------
module spi_cmd_sched #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned POLL_PERIOD = 1000,
  parameter logic [15:0] POLL_CMD    = 16'h8000
) (
  input  logic        spi_clk,
  input  logic        spi_nrst,
  input  logic [15:0] host_cmd,
  input  logic        host_cmd_valid,
  output logic        host_cmd_full,
  output logic        host_drop,
  output logic [15:0] host_rsp,
  output logic        host_rsp_valid,
  input  logic        poll_en,
  output logic [15:0] poll_data,
  output logic        poll_valid,
  output logic        poll_miss,
  output logic        busy,
  input  logic        spi_rdy,
  input  logic        spi_ack,
  input  logic [15:0] spi_in,
  output logic        spi_req,
  output logic [15:0] spi_out
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TERM_C  = TW'(POLL_PERIOD - 1);
  localparam logic SEL_HOST = 1'b0;
  localparam logic SEL_POLL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_sel;
  logic          r_last_grant;
  logic [15:0]   r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [TW-1:0] r_timer;
  logic          r_poll_pend;

  logic          w_host_pend;
  logic          w_grant;
  logic          w_pick_host;
  logic          w_pop;
  logic          w_grant_poll;
  logic          w_push;
  logic          w_tick;
  logic [AW:0]   w_count_nxt;

  // Arbitration, FIFO push/pop qualification and next occupancy.
  always_comb begin
    w_host_pend  = (r_count != {(AW + 1){1'b0}});
    w_grant      = (r_state == ST_IDLE) && spi_rdy && (w_host_pend || r_poll_pend);
    // On a tie the requester that did not win last time goes first.
    if (w_host_pend && r_poll_pend) begin
      w_pick_host = (r_last_grant == SEL_POLL);
    end else begin
      w_pick_host = w_host_pend;
    end
    w_pop        = w_grant && w_pick_host;
    w_grant_poll = w_grant && !w_pick_host;
    w_push       = host_cmd_valid && !host_cmd_full;
    w_tick       = poll_en && (r_timer == TERM_C);
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (AW + 1)'(1);
      2'b01:   w_count_nxt = r_count - (AW + 1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge spi_clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= host_cmd;
    end
  end

  // FIFO pointers, occupancy, full and drop flags.
  always_ff @(posedge spi_clk or negedge spi_nrst) begin
    if (!spi_nrst) begin
      r_wptr        <= {AW{1'b0}};
      r_rptr        <= {AW{1'b0}};
      r_count       <= {(AW + 1){1'b0}};
      host_cmd_full <= 1'b0;
      host_drop     <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count       <= w_count_nxt;
      host_cmd_full <= (w_count_nxt == DEPTH_C);
      if (host_cmd_valid && host_cmd_full) begin
        host_drop <= 1'b1;
      end
    end
  end

  // Poll timer, pending trigger and miss flag.
  always_ff @(posedge spi_clk or negedge spi_nrst) begin
    if (!spi_nrst) begin
      r_timer     <= {TW{1'b0}};
      r_poll_pend <= 1'b0;
      poll_miss   <= 1'b0;
    end else if (!poll_en) begin
      r_timer     <= {TW{1'b0}};
      r_poll_pend <= 1'b0;
    end else begin
      r_timer <= w_tick ? {TW{1'b0}} : (r_timer + TW'(1));
      if (w_tick) begin
        // A trigger landing on the grant edge re-arms instead of missing.
        if (r_poll_pend && !w_grant_poll) begin
          poll_miss <= 1'b1;
        end
        r_poll_pend <= 1'b1;
      end else if (w_grant_poll) begin
        r_poll_pend <= 1'b0;
      end
    end
  end

  // Scheduler FSM with registered handshake and response outputs.
  always_ff @(posedge spi_clk or negedge spi_nrst) begin
    if (!spi_nrst) begin
      r_state        <= ST_IDLE;
      r_sel          <= SEL_HOST;
      r_last_grant   <= SEL_POLL;
      spi_req        <= 1'b0;
      spi_out        <= 16'h0000;
      busy           <= 1'b0;
      host_rsp       <= 16'h0000;
      host_rsp_valid <= 1'b0;
      poll_data      <= 16'h0000;
      poll_valid     <= 1'b0;
    end else begin
      host_rsp_valid <= 1'b0;
      poll_valid     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            spi_out      <= w_pick_host ? r_fifo[r_rptr] : POLL_CMD;
            r_sel        <= w_pick_host ? SEL_HOST : SEL_POLL;
            r_last_grant <= w_pick_host ? SEL_HOST : SEL_POLL;
            spi_req      <= 1'b1;
            busy         <= 1'b1;
            r_state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (spi_ack) begin
            if (r_sel == SEL_HOST) begin
              host_rsp       <= spi_in;
              host_rsp_valid <= 1'b1;
            end else begin
              poll_data  <= spi_in;
              poll_valid <= 1'b1;
            end
            spi_req <= 1'b0;
            r_state <= ST_REL;
          end
        end
        ST_REL: begin
          if (!spi_ack && spi_rdy) begin
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          spi_req <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_sched.sv
// ---------------------------------------------------------------------------
// tb_spi_cmd_sched
//   Self-checking bench for spi_cmd_sched (FIFO_DEPTH=4, POLL_PERIOD=20).
//   A spi_master model answers host words with (cmd ^ KEY) and poll words
//   with poll_rsp after ack_delay cycles. A monitor logs grants and
//   responses; each test task compares those logs with its own expectations.
// ---------------------------------------------------------------------------
module tb_spi_cmd_sched;

  localparam logic [15:0] KEY  = 16'hB791;  // 16'hA5A5 ^ KEY == 16'h1234
  localparam logic [15:0] PCMD = 16'h8000;
  localparam int          PER  = 20;

  logic        spi_clk = 1'b0;
  logic        spi_nrst = 1'b1;
  logic [15:0] host_cmd = 16'h0000;
  logic        host_cmd_valid = 1'b0;
  logic        host_cmd_full;
  logic        host_drop;
  logic [15:0] host_rsp;
  logic        host_rsp_valid;
  logic        poll_en = 1'b0;
  logic [15:0] poll_data;
  logic        poll_valid;
  logic        poll_miss;
  logic        busy;
  logic        spi_rdy = 1'b0;
  logic        spi_ack = 1'b0;
  logic [15:0] spi_in = 16'h0000;
  logic        spi_req;
  logic [15:0] spi_out;

  int          n_checks = 0;
  int          n_fails = 0;
  int          cyc = 0;
  int          ack_delay = 0;
  logic [15:0] poll_rsp = 16'h00C3;

  logic [15:0] q_grant[$];
  int          q_gtime[$];
  logic [15:0] q_hrsp[$];
  logic [15:0] q_prsp[$];
  int          gap_viol = 0;
  int          stab_viol = 0;
  int          m_low = 0;
  bit          m_seen = 1'b0;
  logic        m_prev_req = 1'b0;
  logic [15:0] m_prev_out = 16'h0000;

  spi_cmd_sched #(
    .FIFO_DEPTH (4),
    .POLL_PERIOD(PER),
    .POLL_CMD   (PCMD)
  ) dut (
    .spi_clk       (spi_clk),
    .spi_nrst      (spi_nrst),
    .host_cmd      (host_cmd),
    .host_cmd_valid(host_cmd_valid),
    .host_cmd_full (host_cmd_full),
    .host_drop     (host_drop),
    .host_rsp      (host_rsp),
    .host_rsp_valid(host_rsp_valid),
    .poll_en       (poll_en),
    .poll_data     (poll_data),
    .poll_valid    (poll_valid),
    .poll_miss     (poll_miss),
    .busy          (busy),
    .spi_rdy       (spi_rdy),
    .spi_ack       (spi_ack),
    .spi_in        (spi_in),
    .spi_req       (spi_req),
    .spi_out       (spi_out)
  );

  always #5 spi_clk = ~spi_clk;

  initial begin : cycle_counter
    forever begin
      @(posedge spi_clk);
      cyc++;
    end
  end

  // spi_master model: ack after ack_delay cycles of spi_req, drop with spi_req.
  initial begin : spi_model
    int cnt;
    cnt = 0;
    forever begin
      @(negedge spi_clk);
      if (!spi_nrst) begin
        spi_ack = 1'b0;
        cnt = 0;
      end else if (spi_req && !spi_ack) begin
        if (cnt >= ack_delay) begin
          spi_in  = (spi_out == PCMD) ? poll_rsp : (spi_out ^ KEY);
          spi_ack = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else if (!spi_req) begin
        spi_ack = 1'b0;
      end
    end
  end

  // Monitor: logs grants (word, cycle), responses, gap and stability breaks.
  initial begin : monitor
    forever begin
      @(negedge spi_clk);
      if (spi_req && !m_prev_req) begin
        q_grant.push_back(spi_out);
        q_gtime.push_back(cyc);
        if (m_seen && m_low < 2) gap_viol++;
        m_seen = 1'b1;
      end
      if (spi_req && m_prev_req && spi_out !== m_prev_out) stab_viol++;
      if (!spi_req) m_low++;
      else m_low = 0;
      if (host_rsp_valid) q_hrsp.push_back(host_rsp);
      if (poll_valid) q_prsp.push_back(poll_data);
      m_prev_req = spi_req;
      m_prev_out = spi_out;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic clear_mon();
    q_grant.delete();
    q_gtime.delete();
    q_hrsp.delete();
    q_prsp.delete();
    gap_viol = 0;
    stab_viol = 0;
    m_seen = 1'b0;
    m_low = 0;
  endtask

  task automatic apply_reset();
    spi_nrst = 1'b0;
    host_cmd_valid = 1'b0;
    poll_en = 1'b0;
    spi_rdy = 1'b0;
    repeat (2) @(negedge spi_clk);
    clear_mon();
    spi_nrst = 1'b1;
    spi_rdy = 1'b1;
    @(negedge spi_clk);
  endtask

  // Push one word; returns at the negedge after the push was sampled.
  task automatic push1(input logic [15:0] w);
    host_cmd = w;
    host_cmd_valid = 1'b1;
    @(negedge spi_clk);
    host_cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    spi_nrst = 1'b1;
    #2 spi_nrst = 1'b0;
    repeat (2) @(negedge spi_clk);
    n_checks++;
    if (spi_req !== 1'b0 || busy !== 1'b0) begin
      n_fails++; $display("FAIL reset_req_busy: got req=%b busy=%b, expected 0 0", spi_req, busy);
    end
    n_checks++;
    if (spi_out !== 16'h0000) begin
      n_fails++; $display("FAIL reset_spi_out: got %h, expected 0000", spi_out);
    end
    n_checks++;
    if (host_cmd_full !== 1'b0 || host_drop !== 1'b0 || poll_miss !== 1'b0) begin
      n_fails++; $display("FAIL reset_flags: got full=%b drop=%b miss=%b, expected 0 0 0",
                          host_cmd_full, host_drop, poll_miss);
    end
    n_checks++;
    if (host_rsp !== 16'h0000 || poll_data !== 16'h0000 || host_rsp_valid !== 1'b0 || poll_valid !== 1'b0) begin
      n_fails++; $display("FAIL reset_rsp: got host_rsp=%h poll_data=%h hv=%b pv=%b, expected all 0",
                          host_rsp, poll_data, host_rsp_valid, poll_valid);
    end
  endtask

  task automatic test_host_path();
    apply_reset();
    ack_delay = 2;
    push1(16'hA5A5);
    n_checks++;
    if (spi_req !== 1'b0) begin
      n_fails++; $display("FAIL host_latency_early: got spi_req=%b, expected 0", spi_req);
    end
    @(negedge spi_clk);
    n_checks++;
    if (spi_req !== 1'b1 || spi_out !== 16'hA5A5 || busy !== 1'b1) begin
      n_fails++; $display("FAIL host_grant: got req=%b out=%h busy=%b, expected 1 a5a5 1",
                          spi_req, spi_out, busy);
    end
    for (int i = 0; i < 50 && q_hrsp.size() < 1; i++) @(negedge spi_clk);
    repeat (10) @(negedge spi_clk);
    n_checks++;
    if (q_hrsp.size() != 1 || q_grant.size() != 1) begin
      n_fails++; $display("FAIL host_counts: got %0d rsp %0d grants, expected 1 1", q_hrsp.size(), q_grant.size());
    end
    n_checks++;
    if (q_hrsp.size() < 1 || q_hrsp[0] !== 16'h1234 || host_rsp !== 16'h1234) begin
      n_fails++; $display("FAIL host_rsp: got %h, expected 1234", host_rsp);
    end
    n_checks++;
    if (q_prsp.size() != 0 || stab_viol != 0) begin
      n_fails++; $display("FAIL host_side: got %0d poll pulses %0d stability breaks, expected 0 0",
                          q_prsp.size(), stab_viol);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q[$];
    int total;
    int n;
    total = 0;
    apply_reset();
    for (int b = 0; b < 6; b++) begin
      int nw;
      nw = $urandom_range(1, 4);
      ack_delay = $urandom_range(0, 3);
      for (int i = 0; i < nw; i++) begin
        logic [15:0] w;
        w = 16'($urandom) & 16'h7FFF;
        exp_q.push_back(w);
        push1(w);
      end
      total += nw;
      for (int i = 0; i < 200 && q_hrsp.size() < total; i++) @(negedge spi_clk);
      repeat ($urandom_range(0, 3)) @(negedge spi_clk);
    end
    repeat (8) @(negedge spi_clk);
    n_checks++;
    if (q_grant.size() != total || q_hrsp.size() != total) begin
      n_fails++; $display("FAIL b2b_counts: got %0d grants %0d rsp, expected %0d", q_grant.size(), q_hrsp.size(), total);
    end
    n = (q_hrsp.size() < q_grant.size()) ? q_hrsp.size() : q_grant.size();
    if (n > total) n = total;
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (q_grant[i] !== exp_q[i] || q_hrsp[i] !== (exp_q[i] ^ KEY)) begin
        n_fails++; $display("FAIL b2b_txn%0d: got out=%h rsp=%h, expected %h %h",
                            i, q_grant[i], q_hrsp[i], exp_q[i], exp_q[i] ^ KEY);
      end
    end
    n_checks++;
    if (gap_viol != 0 || stab_viol != 0 || host_drop !== 1'b0 || q_prsp.size() != 0) begin
      n_fails++; $display("FAIL b2b_rules: got gap=%0d stab=%0d drop=%b poll=%0d, expected 0 0 0 0",
                          gap_viol, stab_viol, host_drop, q_prsp.size());
    end
  endtask

  task automatic test_overflow();
    logic [15:0] w5 [5];
    apply_reset();
    spi_rdy = 1'b0;
    ack_delay = 1;
    for (int i = 0; i < 5; i++) w5[i] = 16'($urandom) & 16'h7FFF;
    for (int i = 0; i < 5; i++) begin
      push1(w5[i]);
      n_checks++;
      if (host_cmd_full !== ((i >= 3) ? 1'b1 : 1'b0) || host_drop !== ((i == 4) ? 1'b1 : 1'b0)) begin
        n_fails++; $display("FAIL ovf_push%0d: got full=%b drop=%b, expected %b %b",
                            i, host_cmd_full, host_drop, (i >= 3), (i == 4));
      end
    end
    spi_rdy = 1'b1;
    for (int i = 0; i < 200 && q_hrsp.size() < 4; i++) @(negedge spi_clk);
    repeat (20) @(negedge spi_clk);
    n_checks++;
    if (q_grant.size() != 4 || q_hrsp.size() != 4) begin
      n_fails++; $display("FAIL ovf_counts: got %0d grants %0d rsp, expected 4 4", q_grant.size(), q_hrsp.size());
    end
    for (int i = 0; i < 4 && i < q_grant.size() && i < q_hrsp.size(); i++) begin
      n_checks++;
      if (q_grant[i] !== w5[i] || q_hrsp[i] !== (w5[i] ^ KEY)) begin
        n_fails++; $display("FAIL ovf_order%0d: got out=%h rsp=%h, expected %h %h",
                            i, q_grant[i], q_hrsp[i], w5[i], w5[i] ^ KEY);
      end
    end
  endtask

  task automatic test_poll_path();
    int t0;
    apply_reset();
    ack_delay = 1;
    poll_rsp = 16'h00C3;
    poll_en = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 120 && q_prsp.size() < 3; i++) @(negedge spi_clk);
    repeat (3) @(negedge spi_clk);
    n_checks++;
    if (q_prsp.size() < 3 || q_gtime.size() < 3) begin
      n_fails++; $display("FAIL poll_count: got %0d polls, expected at least 3", q_prsp.size());
    end
    for (int i = 0; i < 3 && i < q_gtime.size() && i < q_prsp.size(); i++) begin
      n_checks++;
      if (q_grant[i] !== PCMD || q_prsp[i] !== 16'h00C3 || (q_gtime[i] - t0) != 21 + i * PER) begin
        n_fails++; $display("FAIL poll_txn%0d: got out=%h data=%h at +%0d, expected 8000 00c3 at +%0d",
                            i, q_grant[i], q_prsp[i], q_gtime[i] - t0, 21 + i * PER);
      end
    end
    n_checks++;
    if (q_hrsp.size() != 0 || poll_miss !== 1'b0) begin
      n_fails++; $display("FAIL poll_side: got %0d host pulses miss=%b, expected 0 0", q_hrsp.size(), poll_miss);
    end
    poll_en = 1'b0;
  endtask

  task automatic test_arbitration();
    logic [15:0] h [3];
    logic [15:0] exp_g [6];
    apply_reset();
    ack_delay = 25;
    poll_rsp = 16'($urandom);
    for (int i = 0; i < 3; i++) h[i] = 16'($urandom) & 16'h7FFF;
    exp_g[0] = h[0]; exp_g[1] = PCMD; exp_g[2] = h[1];
    exp_g[3] = PCMD; exp_g[4] = h[2]; exp_g[5] = PCMD;
    poll_en = 1'b1;
    repeat (PER - 1) @(negedge spi_clk);
    // first push is sampled on the same edge as the first poll trigger
    for (int i = 0; i < 3; i++) push1(h[i]);
    for (int i = 0; i < 400 && q_grant.size() < 6; i++) @(negedge spi_clk);
    n_checks++;
    if (q_grant.size() < 6) begin
      n_fails++; $display("FAIL arb_count: got %0d grants, expected 6", q_grant.size());
    end
    for (int i = 0; i < 6 && i < q_grant.size(); i++) begin
      n_checks++;
      if (q_grant[i] !== exp_g[i]) begin
        n_fails++; $display("FAIL arb_order%0d: got %h, expected %h", i, q_grant[i], exp_g[i]);
      end
    end
    n_checks++;
    if (q_hrsp.size() != 3 || q_hrsp[0] !== (h[0] ^ KEY) || q_hrsp[2] !== (h[2] ^ KEY) ||
        q_prsp.size() < 2 || q_prsp[0] !== poll_rsp) begin
      n_fails++; $display("FAIL arb_rsp: got %0d host rsp first=%h, %0d poll rsp, expected 3 %h, >=2",
                          q_hrsp.size(), q_hrsp[0], q_prsp.size(), h[0] ^ KEY);
    end
    poll_en = 1'b0;
    repeat (40) @(negedge spi_clk);
  endtask

  task automatic test_poll_miss();
    int t0;
    apply_reset();
    ack_delay = 45;
    poll_rsp = 16'($urandom);
    poll_en = 1'b1;
    t0 = cyc;
    while (cyc - t0 < 50) @(negedge spi_clk);
    n_checks++;
    if (poll_miss !== 1'b0) begin
      n_fails++; $display("FAIL miss_early: got %b, expected 0", poll_miss);
    end
    while (cyc - t0 < 65) @(negedge spi_clk);
    n_checks++;
    if (poll_miss !== 1'b1) begin
      n_fails++; $display("FAIL miss_set: got %b, expected 1", poll_miss);
    end
    // a poll is in flight and another is queued; disabling drops the queued one
    poll_en = 1'b0;
    repeat (100) @(negedge spi_clk);
    n_checks++;
    if (q_grant.size() != 1 || q_prsp.size() != 1 || poll_data !== poll_rsp) begin
      n_fails++; $display("FAIL miss_drain: got %0d grants %0d rsp data=%h, expected 1 1 %h",
                          q_grant.size(), q_prsp.size(), poll_data, poll_rsp);
    end
    n_checks++;
    if (poll_miss !== 1'b1 || busy !== 1'b0) begin
      n_fails++; $display("FAIL miss_sticky: got miss=%b busy=%b, expected 1 0", poll_miss, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] w;
    apply_reset();
    ack_delay = 10;
    push1(16'h1111);
    push1(16'h2222);
    repeat (3) @(negedge spi_clk);
    n_checks++;
    if (spi_req !== 1'b1) begin
      n_fails++; $display("FAIL rstmid_pre: got spi_req=%b, expected 1", spi_req);
    end
    #2 spi_nrst = 1'b0;
    #1;
    n_checks++;
    if (spi_req !== 1'b0 || busy !== 1'b0 || host_cmd_full !== 1'b0 || spi_out !== 16'h0000) begin
      n_fails++; $display("FAIL rstmid_async: got req=%b busy=%b full=%b out=%h, expected 0 0 0 0000",
                          spi_req, busy, host_cmd_full, spi_out);
    end
    repeat (3) @(negedge spi_clk);
    n_checks++;
    if (q_hrsp.size() != 0 || host_rsp_valid !== 1'b0) begin
      n_fails++; $display("FAIL rstmid_nopulse: got %0d host pulses, expected 0", q_hrsp.size());
    end
    clear_mon();
    spi_nrst = 1'b1;
    @(negedge spi_clk);
    ack_delay = 1;
    w = 16'($urandom) & 16'h7FFF;
    push1(w);
    for (int i = 0; i < 50 && q_hrsp.size() < 1; i++) @(negedge spi_clk);
    repeat (10) @(negedge spi_clk);
    n_checks++;
    if (q_grant.size() != 1 || q_grant[0] !== w || q_hrsp.size() != 1 || q_hrsp[0] !== (w ^ KEY)) begin
      n_fails++; $display("FAIL rstmid_after: got %0d grants first=%h, %0d rsp, expected 1 %h 1",
                          q_grant.size(), q_grant[0], q_hrsp.size(), w);
    end
  endtask

  initial begin : main
    test_reset();
    test_host_path();
    test_back_to_back();
    test_overflow();
    test_poll_path();
    test_arbitration();
    test_poll_miss();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
